// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the dmem arbiter: FSM states and dmem size codes.
package dmem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   // Access size codes shared by the core and dmem lwhb/swhb pins
   localparam logic [1:0] SZ_WORD = 2'b11;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_BYTE = 2'b01;

   // dmem pin encodings when nothing is granted: no store, word-sized load
   localparam logic [1:0] SWHB_NONE = 2'b00;
   localparam logic [1:0] LWHB_IDLE = SZ_WORD;

endpackage

// File: rtl/dmem_burst_agen.sv
// DMA burst address generator: latches base/length/direction on start and
// walks base + 4*beat, flagging the last beat and the done pulse.
module dmem_burst_agen
   import dmem_arbiter_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MAX_BURST = 8,
   parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_advance,
   input  logic             i_abort,
   input  logic [XLEN-1:0]  i_base,
   input  logic             i_we,
   input  logic [LEN_W-1:0] i_len,
   output logic [XLEN-1:0]  o_addr,
   output logic             o_we,
   output logic             o_last_beat,
   output logic             o_done,
   output logic             o_multi
);

   logic [XLEN-1:0]  r_base;
   logic [LEN_W-1:0] r_len;
   logic             r_we;
   logic [LEN_W-1:0] r_beat;
   logic [LEN_W-1:0] w_len_eff;

   // A zero length means one beat; oversize requests are clipped
   always_comb begin
      w_len_eff = i_len;
      if (i_len == '0)
         w_len_eff = LEN_W'(1);
      else if (i_len > LEN_W'(MAX_BURST))
         w_len_eff = LEN_W'(MAX_BURST);
   end

   assign o_addr      = r_base + XLEN'({r_beat, 2'b00});
   assign o_we        = r_we;
   assign o_last_beat = (r_beat == (r_len - LEN_W'(1)));
   assign o_multi     = (w_len_eff > LEN_W'(1));
   // Beat 0 is done immediately for single-beat bursts
   assign o_done      = i_start ? !o_multi : (i_advance & o_last_beat);

   // Latch burst descriptor on start, step the beat counter on each advance
   always_ff @(posedge clk) begin
      if (reset || i_abort) begin
         r_beat <= '0;
      end else if (i_start) begin
         r_base <= i_base;
         r_len  <= w_len_eff;
         r_we   <= i_we;
         r_beat <= LEN_W'(1);
      end else if (i_advance) begin
         r_beat <= o_last_beat ? '0 : r_beat + LEN_W'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: core has per-cycle priority, DMA gets starvation
// protection and may own the memory for a multi-beat word burst.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int MAX_BURST    = 8,
   parameter int STARVE_LIMIT = 4,
   parameter int LEN_W        = $clog2(MAX_BURST) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c_req,
   input  logic             c_we,
   input  logic [XLEN-1:0]  c_addr,
   input  logic [XLEN-1:0]  c_wdata,
   input  logic [1:0]       c_lwhb,
   input  logic [1:0]       c_swhb,
   input  logic             c_lu,
   output logic             c_gnt,
   output logic             c_rvalid,
   output logic [XLEN-1:0]  c_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [XLEN-1:0]  d_addr,
   input  logic [LEN_W-1:0] d_len,
   input  logic [XLEN-1:0]  d_wdata,
   output logic             d_gnt,
   output logic             d_done,
   output logic             d_rvalid,
   output logic [XLEN-1:0]  d_rdata,
   output logic             m_we,
   output logic [XLEN-1:0]  m_a,
   output logic [XLEN-1:0]  m_wd,
   output logic [1:0]       m_lwhb,
   output logic [1:0]       m_swhb,
   output logic             m_lu,
   input  logic [XLEN-1:0]  m_rd
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t      r_state;
   logic [SC_W-1:0] r_starve;
   logic            r_c_rvalid, r_d_rvalid;
   logic [XLEN-1:0] r_c_rdata, r_d_rdata;

   logic            w_idle, w_starved, w_d_win, w_d_beat, w_abort;
   logic [XLEN-1:0] w_base, w_burst_addr;
   logic            w_burst_we, w_last, w_multi, w_d_we_cur;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_starved  = (r_starve == SC_W'(STARVE_LIMIT));
   assign w_d_win    = !reset & w_idle & d_req & (w_starved | !c_req);
   assign w_d_beat   = !reset & !w_idle & d_req;
   assign w_abort    = !w_idle & !d_req;
   assign c_gnt      = !reset & w_idle & c_req & !w_d_win;
   assign d_gnt      = w_d_win | w_d_beat;
   assign w_base     = d_addr & ~XLEN'(3);
   assign w_d_we_cur = w_idle ? d_we : w_burst_we;

   assign c_rvalid = r_c_rvalid;
   assign c_rdata  = r_c_rdata;
   assign d_rvalid = r_d_rvalid;
   assign d_rdata  = r_d_rdata;

   dmem_burst_agen #(
      .XLEN      (XLEN),
      .MAX_BURST (MAX_BURST),
      .LEN_W     (LEN_W)
   ) u_agen (
      .clk         (clk),
      .reset       (reset),
      .i_start     (w_d_win),
      .i_advance   (w_d_beat),
      .i_abort     (w_abort),
      .i_base      (w_base),
      .i_we        (d_we),
      .i_len       (d_len),
      .o_addr      (w_burst_addr),
      .o_we        (w_burst_we),
      .o_last_beat (w_last),
      .o_done      (d_done),
      .o_multi     (w_multi)
   );

   // Steer the winning requester onto the dmem pins, idle values otherwise
   always_comb begin
      m_we   = 1'b0;
      m_a    = '0;
      m_wd   = '0;
      m_lwhb = LWHB_IDLE;
      m_swhb = SWHB_NONE;
      m_lu   = 1'b0;
      if (c_gnt) begin
         m_we   = c_we;
         m_a    = c_addr;
         m_wd   = c_wdata;
         m_lwhb = c_lwhb;
         m_swhb = c_swhb;
         m_lu   = c_lu;
      end else if (d_gnt) begin
         m_we   = w_d_we_cur;
         m_a    = w_idle ? w_base : w_burst_addr;
         m_wd   = d_wdata;
         m_lwhb = SZ_WORD;
         m_swhb = SZ_WORD;
      end
   end

   // Arbitration FSM: IDLE arbitrates per cycle, BURST hands dmem to the DMA
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_d_win && w_multi) r_state <= ST_BURST;
            ST_BURST: if (!d_req || w_last)   r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Count consecutive denied DMA cycles, saturating at the limit
   always_ff @(posedge clk) begin
      if (reset || d_gnt)
         r_starve <= '0;
      else if (w_idle && d_req && !w_starved)
         r_starve <= r_starve + SC_W'(1);
   end

   // Register read data back to whichever requester issued the load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_c_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_c_rvalid <= c_gnt & !c_we;
         r_d_rvalid <= d_gnt & !w_d_we_cur;
         if (c_gnt && !c_we) r_c_rdata <= m_rd;
         if (d_gnt && !w_d_we_cur) r_d_rdata <= m_rd;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed dmem model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, c_lu;
   logic [31:0] c_addr, c_wdata;
   logic [1:0]  c_lwhb, c_swhb;
   logic        c_gnt, c_rvalid;
   logic [31:0] c_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_len;
   logic        d_gnt, d_done, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_we, m_lu;
   logic [31:0] m_a, m_wd, m_rd;
   logic [1:0]  m_lwhb, m_swhb;

   logic [31:0] mem [0:1023];
   logic        mem_init;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.XLEN(32), .MAX_BURST(8), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_lwhb(c_lwhb), .c_swhb(c_swhb), .c_lu(c_lu),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_we(m_we), .m_a(m_a), .m_wd(m_wd), .m_lwhb(m_lwhb), .m_swhb(m_swhb),
      .m_lu(m_lu), .m_rd(m_rd)
   );

   // Word memory; initial content of word i is 0xC0DE0000 | i
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | i;
      end else if (m_we) begin
         mem[m_a[11:2]] <= m_wd;
      end
   end
   assign m_rd = mem[m_a[11:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      c_req = 0; c_we = 0; c_lu = 0; c_addr = 0; c_wdata = 0;
      c_lwhb = 2'b11; c_swhb = 2'b11;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_len = 0;
      repeat (3) cyc();
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_d_done", d_done, 0);
      chk("rst_c_rvalid", c_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_a", m_a, 0);
      reset = 1'b0; mem_init = 1'b0;
      cyc();

      // Core word store then load at 0x10
      c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
      #1;
      chk("cst_gnt", c_gnt, 1);
      chk("cst_m_we", m_we, 1);
      chk("cst_m_a", m_a, 32'h10);
      chk("cst_m_wd", m_wd, 32'hDEADBEEF);
      cyc();
      chk("cst_mem", mem[4], 32'hDEADBEEF);
      c_we = 0;
      #1;
      chk("cld_gnt", c_gnt, 1);
      chk("cld_m_we", m_we, 0);
      cyc();
      c_req = 0;
      #1;
      chk("cld_rvalid", c_rvalid, 1);
      chk("cld_rdata", c_rdata, 32'hDEADBEEF);
      cyc();
      chk("cld_rvalid_pulse", c_rvalid, 0);

      // Simultaneous single requests: core first, DMA next cycle (len 0 -> 1)
      c_req = 1; d_req = 1; d_we = 0; d_addr = 32'h103; d_len = 0;
      #1;
      chk("sim_c_gnt", c_gnt, 1);
      chk("sim_d_gnt0", d_gnt, 0);
      cyc();
      c_req = 0;
      #1;
      chk("sim_d_gnt1", d_gnt, 1);
      chk("sim_m_a", m_a, 32'h100);
      chk("sim_d_done", d_done, 1);
      cyc();
      d_req = 0;
      #1;
      chk("sim_d_rvalid", d_rvalid, 1);
      chk("sim_d_rdata", d_rdata, 32'hC0DE0040);
      cyc();

      // Starvation: core every cycle, DMA continuous; DMA wins on cycle 5
      c_req = 1; c_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20; d_len = 1;
      for (int i = 1; i <= 6; i++) begin
         #1;
         chk($sformatf("stv_d_gnt%0d", i), d_gnt, (i == 5));
         chk($sformatf("stv_c_gnt%0d", i), c_gnt, (i != 5));
         cyc();
      end
      c_req = 0; d_req = 0;
      cyc();

      // 4-beat write burst from 0x3FC; core request arrives mid-burst
      d_req = 1; d_we = 1; d_addr = 32'h3FC; d_len = 4;
      for (int k = 0; k < 4; k++) begin
         d_wdata = k + 1;
         if (k == 1) begin c_req = 1; c_we = 0; c_addr = 32'h10; end
         #1;
         chk($sformatf("bw_gnt%0d", k), d_gnt, 1);
         chk($sformatf("bw_m_a%0d", k), m_a, 32'h3FC + 4 * k);
         chk($sformatf("bw_m_we%0d", k), m_we, 1);
         chk($sformatf("bw_done%0d", k), d_done, (k == 3));
         if (k > 0) chk($sformatf("bw_c_blk%0d", k), c_gnt, 0);
         cyc();
      end
      d_req = 0;
      #1;
      chk("bw_c_after", c_gnt, 1);
      chk("bw_c_m_a", m_a, 32'h10);
      cyc();
      c_req = 0;
      chk("bw_mem0", mem[10'h0FF], 1);
      chk("bw_mem1", mem[10'h100], 2);
      chk("bw_mem2", mem[10'h101], 3);
      chk("bw_mem3", mem[10'h102], 4);

      // 6-beat read aborted after beat 2
      d_req = 1; d_we = 0; d_addr = 32'h200; d_len = 6;
      #1;
      chk("ab_gnt0", d_gnt, 1);
      chk("ab_m_a0", m_a, 32'h200);
      cyc();
      #1;
      chk("ab_gnt1", d_gnt, 1);
      chk("ab_m_a1", m_a, 32'h204);
      chk("ab_rv1", d_rvalid, 1);
      chk("ab_rd1", d_rdata, 32'hC0DE0080);
      cyc();
      d_req = 0;
      #1;
      chk("ab_gnt2", d_gnt, 0);
      chk("ab_done2", d_done, 0);
      chk("ab_m_we2", m_we, 0);
      chk("ab_rv2", d_rvalid, 1);
      chk("ab_rd2", d_rdata, 32'hC0DE0081);
      cyc();
      c_req = 1;
      #1;
      chk("ab_rv3", d_rvalid, 0);
      chk("ab_idle_c_gnt", c_gnt, 1);
      cyc();
      c_req = 0;

      // Address wrap: 2 beats from 0xFFFFFFFC
      d_req = 1; d_we = 0; d_addr = 32'hFFFFFFFC; d_len = 2;
      #1;
      chk("wr_m_a0", m_a, 32'hFFFFFFFC);
      cyc();
      #1;
      chk("wr_m_a1", m_a, 32'h0);
      chk("wr_done1", d_done, 1);
      chk("wr_rd0", d_rdata, 32'hC0DE03FF);
      cyc();
      d_req = 0;
      #1;
      chk("wr_rd1", d_rdata, 32'hC0DE0000);
      cyc();

      // Oversize length clipped to 8 beats
      d_req = 1; d_we = 0; d_addr = 32'h40; d_len = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("cl_gnt%0d", k), d_gnt, 1);
         chk($sformatf("cl_done%0d", k), d_done, (k == 7));
         cyc();
      end
      d_req = 0;
      #1;
      chk("cl_gnt_end", d_gnt, 0);
      cyc();

      // Reset during the third beat of a write burst at 0x300
      d_req = 1; d_we = 1; d_addr = 32'h300; d_len = 6;
      for (int k = 0; k < 2; k++) begin
         d_wdata = 32'hA0 + k;
         #1;
         chk($sformatf("rb_m_a%0d", k), m_a, 32'h300 + 4 * k);
         cyc();
      end
      d_wdata = 32'hA2; reset = 1;
      #1;
      chk("rb_m_we", m_we, 0);
      chk("rb_d_gnt", d_gnt, 0);
      cyc();
      reset = 0; d_req = 0;
      #1;
      chk("rb_post_d_gnt", d_gnt, 0);
      chk("rb_post_d_done", d_done, 0);
      chk("rb_post_d_rvalid", d_rvalid, 0);
      chk("rb_post_c_rvalid", c_rvalid, 0);
      chk("rb_post_d_rdata", d_rdata, 0);
      chk("rb_post_c_rdata", c_rdata, 0);
      chk("rb_post_m_a", m_a, 0);
      chk("rb_post_m_we", m_we, 0);
      chk("rb_mem0", mem[10'h0C0], 32'hA0);
      chk("rb_mem1", mem[10'h0C1], 32'hA1);
      chk("rb_mem2", mem[10'h0C2], 32'hC0DE00C2);
      c_req = 1;
      #1;
      chk("rb_idle_c_gnt", c_gnt, 1);
      cyc();
      c_req = 0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmem`) between the core load/store unit and a DMA engine. Core has priority per cycle, the DMA gets starvation protection, and a DMA may hold the memory for a multi-beat word burst. The block sits between the pipeline MEM stage and DMA on one side and `dmem` on the other. It drives the memory's `we/a/wd/lwhb/swhb/lu` pins and returns read data registered to the winning requester.

## Interface
- `XLEN`, 32, data and address width.
- `MAX_BURST`, 8, maximum DMA beats per burst; `d_len` is a log2(MAX_BURST)+1-bit field.
- `STARVE_LIMIT`, 4, consecutive denied DMA cycles after which the DMA beats the core.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `c_req`  in  1  core access request; the core holds it with its fields stable until `c_gnt`.
- `c_we`  in  1  core store.
- `c_addr`  in  XLEN  core byte address.
- `c_wdata`  in  XLEN  core store data.
- `c_lwhb`, `c_swhb`  in  2  size code: 11 word, 10 half, 01 byte.
- `c_lu`  in  1  unsigned load.
- `c_gnt`  out  1  the core access is performed this cycle.
- `c_rvalid`  out  1  `c_rdata` is valid; high the cycle after a granted core load.
- `c_rdata`  out  XLEN  registered load data.
- `d_req`  in  1  DMA request; it must stay high for the whole burst.
- `d_we`  in  1  burst direction; 1 means write.
- `d_addr`  in  XLEN  burst base address; bits [1:0] are ignored.
- `d_len`  in  4  beat count; 0 is treated as 1, and values above MAX_BURST are clipped to MAX_BURST.
- `d_wdata`  in  XLEN  write data for the current beat; it is consumed when `d_gnt` is high.
- `d_gnt`  out  1  one beat is performed this cycle.
- `d_done`  out  1  pulse coinciding with the last beat's `d_gnt`.
- `d_rvalid`  out  1  / `d_rdata`  out  XLEN  registered read beat, valid one cycle after its `d_gnt`.
- `m_we`  out  1  / `m_a`, `m_wd`  out  XLEN  / `m_lwhb`, `m_swhb`  out  2  / `m_lu`  out  1  drive the `dmem` pins.
- `m_rd`  in  XLEN  combinational read data from `dmem`.

## Operation
- FSM states:
  - `IDLE`: per-cycle arbitration.
  - `BURST`: the DMA owns the memory.
- In `IDLE`, the winner is chosen as follows:
  - The DMA wins if `d_req` is high and `starve_cnt == STARVE_LIMIT`.
  - Otherwise the core wins if `c_req` is high.
  - Otherwise the DMA wins if `d_req` is high.
  - Otherwise there is no grant.
- When the core wins: assert `c_gnt` and pass the core fields straight through to the `m_*` pins.
- When the DMA wins in `IDLE`:
  - That cycle is beat 0: `m_a = {d_addr[XLEN-1:2],2'b00}`, `m_lwhb = m_swhb = 11`, `m_lu = 0`.
  - Latch the base address, `d_we` and the effective length.
  - Set `beat = 1`.
  - Go to `BURST` if the effective length is greater than 1; otherwise pulse `d_done` and stay in `IDLE`.
- In `BURST`:
  - `c_gnt = 0`.
  - Each cycle with `d_req` high is beat `k`: `m_a = base + 4k`, using modulo 2^XLEN arithmetic, so wrap is silent.
  - After the last beat, pulse `d_done` and go to `IDLE`.
- If `d_req` drops in `BURST`, the burst is aborted:
  - No grant and no write that cycle.
  - The FSM goes to `IDLE` next cycle.
  - `d_done` is not asserted.
- `m_we`:
  - Equals `c_we` on a core grant, the latched `d_we` on a DMA grant, and 0 otherwise.
  - Forced 0 whenever `reset` is high.
- With no grant, the memory pins take idle values: `m_a = 0`, `m_wd = 0`, `m_swhb = 00`, `m_lwhb = 11`, `m_lu = 0`.
- `starve_cnt`:
  - Increments, saturating at STARVE_LIMIT, on each cycle where `d_req` is high with no `d_gnt` in `IDLE`.
  - Clears on any `d_gnt`.
  - Holds when `d_req` is low.
- Read return: on a granted read, register `m_rd` into the requester's `*_rdata` and pulse its `*_rvalid` the next cycle. `*_rdata` holds its value otherwise.

## Timing
- Grant is combinational from `req` and state, in the same cycle. A write commits on the edge that ends the grant cycle.
- Read latency is 1 cycle from grant to `rvalid`.
- An N-beat uncontested burst takes N consecutive cycles. Its first read `d_rvalid` arrives at cycle 1, and its last at cycle N.
- The worst-case DMA wait with a continuously requesting core is STARVE_LIMIT cycles.
- A core request during a burst waits at most MAX_BURST−1 further cycles.
- Reset value of every output: grants 0, `d_done` 0, both `rvalid` 0, both `rdata` 0, `m_we` 0, `m_a` 0.
- Reset also returns state to `IDLE`, `starve_cnt` to 0 and `beat` to 0.
- Reset mid-burst abandons the burst with no write on the reset edge.

## Structure
- Shared package holds:
  - State encodings `ST_IDLE`, `ST_BURST`.
  - Size codes `SZ_WORD = 2'b11`, `SZ_HALF = 2'b10`, `SZ_BYTE = 2'b01`.
  - The `dmem` size-code encodings used by `dmem`.
- Sub-module `dmem_burst_agen`: latches base, length and direction; generates `base + 4·beat`, `last_beat` and `d_done`. Its interface is start, advance, abort and reset.
- Arbitration, `starve_cnt` and the read-return registers live in the top module.

## Test plan
- Core only: word store of 0xDEADBEEF at 0x10, then a word load at 0x10 → `c_gnt` is high the same cycle as each request, and the cycle after the load `c_rvalid = 1`, `c_rdata = 0xDEADBEEF`.
- Simultaneous single requests, `starve_cnt = 0` → the core wins; the DMA wins the following cycle; `starve_cnt` returns to 0.
- Core requesting every cycle and DMA requesting continuously with `STARVE_LIMIT = 4` → the DMA is granted exactly on the 5th cycle.
- DMA write burst with `d_len = 4`, base 0x3FC, data 1..4 → `m_a` sequence 0x3FC, 0x400, 0x404, 0x408; `d_done` on beat 4; a core request during the burst is granted the cycle after `d_done`.
- `d_req` dropped after beat 2 of a 6-beat read → no further `d_gnt`, no `d_done`, two `d_rvalid` pulses, FSM back in `IDLE`.
- `reset` asserted in beat 3 of a write burst → `m_we = 0` that cycle, all outputs at reset values next cycle, and the memory word for beat 3 is unchanged.
